// File: rtl/tl_pkg.sv
// Shared types and constants for the transaction-layer egress path.
// Holds the drain FSM encoding and the round-robin lane picker.
package tl_pkg;

  localparam int DATA_W = 10;
  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  typedef enum logic [1:0] {
    DRN_IDLE  = 2'd0,
    DRN_RUN   = 2'd1,
    DRN_FLUSH = 2'd2
  } drn_state_e;

  // Returns {found, lane}: first non-empty lane at or after ptr, wrapping 3->0.
  function automatic logic [LANE_W:0] rr_pick(
    input logic [LANES-1:0]  nonempty,
    input logic [LANE_W-1:0] ptr
  );
    logic [LANE_W:0]   res;
    logic [LANE_W-1:0] idx;
    res = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      idx = ptr + LANE_W'(k);
      if (nonempty[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/tl_skid_buf.sv
// Two-entry FIFO holding {lane, data}; absorbs the FIFO read latency so
// words already popped upstream always have a slot to land in.
module tl_skid_buf #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_valid,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Head only moves on a pop, so it stays stable while the sink stalls.
  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_occ != 2'd0);
  assign o_occ   = r_occ;

endmodule

// File: rtl/tl_egress_drain.sv
// Drains four output FIFOs round-robin into one lane-tagged ready/valid
// egress stream, with an idle flag and a forwarded-word counter.
module tl_egress_drain
  import tl_pkg::*;
#(
  parameter int DATA_W     = tl_pkg::DATA_W,
  parameter int CNT_W      = 16,
  parameter int SKID_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              empty0,
  input  logic              empty1,
  input  logic              empty2,
  input  logic              empty3,
  input  logic [DATA_W-1:0] fifo_data0,
  input  logic [DATA_W-1:0] fifo_data1,
  input  logic [DATA_W-1:0] fifo_data2,
  input  logic [DATA_W-1:0] fifo_data3,
  output logic              pop0,
  output logic              pop1,
  output logic              pop2,
  output logic              pop3,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_lane,
  output logic              idle,
  output logic [CNT_W-1:0]  fwd_count,
  output logic [1:0]        dbg_state
);

  drn_state_e         r_state;
  logic [LANE_W-1:0]  r_rr_ptr;
  logic               r_inflight;
  logic [LANE_W-1:0]  r_inflight_lane;
  logic [CNT_W-1:0]   r_fwd_count;

  logic [LANES-1:0]   w_nonempty;
  logic [LANE_W:0]    w_pick;
  logic               w_pop_any;
  logic [LANE_W-1:0]  w_pop_lane;
  logic               w_xfer;
  logic               w_valid;
  logic [1:0]         w_occ;
  logic [1:0]         w_occ_next;
  logic [2:0]         w_outstanding;
  logic [DATA_W-1:0]  w_fifo_data;
  logic [LANE_W+DATA_W-1:0] w_head;

  assign w_nonempty = ~{empty3, empty2, empty1, empty0};
  assign w_pick     = rr_pick(w_nonempty, r_rr_ptr);
  assign w_xfer     = w_valid & out_ready;

  // A word leaving this cycle frees its slot in time for a pop issued now,
  // which is what sustains one word per cycle with the sink ready.
  assign w_outstanding = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_xfer};
  assign w_occ_next    = w_occ + {1'b0, r_inflight} - {1'b0, w_xfer};

  assign w_pop_any  = (r_state == DRN_RUN) && w_pick[LANE_W] &&
                      (w_outstanding < 3'(SKID_DEPTH));
  assign w_pop_lane = w_pick[LANE_W-1:0];

  assign pop0 = w_pop_any && (w_pop_lane == 2'd0);
  assign pop1 = w_pop_any && (w_pop_lane == 2'd1);
  assign pop2 = w_pop_any && (w_pop_lane == 2'd2);
  assign pop3 = w_pop_any && (w_pop_lane == 2'd3);

  always_comb begin
    w_fifo_data = '0;
    case (r_inflight_lane)
      2'd0:    w_fifo_data = fifo_data0;
      2'd1:    w_fifo_data = fifo_data1;
      2'd2:    w_fifo_data = fifo_data2;
      default: w_fifo_data = fifo_data3;
    endcase
  end

  tl_skid_buf #(
    .W (LANE_W + DATA_W)
  ) u_skid (
    .clk         (clk),
    .i_reset     (reset),
    .i_push      (r_inflight),
    .i_push_data ({r_inflight_lane, w_fifo_data}),
    .i_pop       (w_xfer),
    .o_head      (w_head),
    .o_valid     (w_valid),
    .o_occ       (w_occ)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= DRN_IDLE;
      r_rr_ptr        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_lane <= '0;
      r_fwd_count     <= '0;
    end else begin
      r_inflight <= w_pop_any;
      if (w_pop_any) begin
        r_inflight_lane <= w_pop_lane;
        r_rr_ptr        <= w_pop_lane + 2'd1;
      end
      if (w_xfer) r_fwd_count <= r_fwd_count + CNT_W'(1);
      case (r_state)
        DRN_IDLE:  if (enable) r_state <= DRN_RUN;
        DRN_RUN:   if (!enable) r_state <= DRN_FLUSH;
        // Leave FLUSH as soon as this cycle empties the path, so idle rises
        // the cycle right after the last word is accepted.
        DRN_FLUSH: begin
          if (enable) r_state <= DRN_RUN;
          else if (w_occ_next == 2'd0 && !w_pop_any) r_state <= DRN_IDLE;
        end
        default:   r_state <= DRN_IDLE;
      endcase
    end
  end

  assign out_valid = w_valid;
  assign out_data  = w_head[DATA_W-1:0];
  assign out_lane  = w_head[LANE_W+DATA_W-1:DATA_W];
  assign idle      = (r_state == DRN_IDLE) && (w_occ == 2'd0) && !r_inflight;
  assign fwd_count = r_fwd_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tl_egress_drain.sv
// Directed bench for tl_egress_drain: FIFO lane model, event logs and
// per-scenario tasks with inline expected-value comparisons.
module tb_tl_egress_drain;

  typedef struct {
    int         cyc;
    logic [1:0] lane;
    logic [9:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  empty_v = 4'hF;
  logic [9:0]  fd [4] = '{default: '0};
  logic        pop0, pop1, pop2, pop3;
  logic        out_valid;
  logic [9:0]  out_data;
  logic [1:0]  out_lane;
  logic        idle;
  logic [15:0] fwd_count;
  logic [1:0]  dbg_state;

  logic [9:0]  lane_q [4][$];
  ev_t         pop_log[$];
  ev_t         obs_q[$];
  logic [11:0] exp_q[$];

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          viol_cnt = 0;
  int          xfer_total = 0;
  int          idle_rise_cyc = -1;
  logic [3:0]  pop_s = 4'h0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_reset = 1'b1, prev_idle = 1'b0;
  logic [11:0] prev_word = '0;

  tl_egress_drain dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .empty0     (empty_v[0]),
    .empty1     (empty_v[1]),
    .empty2     (empty_v[2]),
    .empty3     (empty_v[3]),
    .fifo_data0 (fd[0]),
    .fifo_data1 (fd[1]),
    .fifo_data2 (fd[2]),
    .fifo_data3 (fd[3]),
    .pop0       (pop0),
    .pop1       (pop1),
    .pop2       (pop2),
    .pop3       (pop3),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .idle       (idle),
    .fwd_count  (fwd_count),
    .dbg_state  (dbg_state)
  );

  // clock / cycle counter / FIFO lane model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pop_s[i] && lane_q[i].size() > 0) fd[i] <= lane_q[i].pop_front();
      empty_v[i] <= (lane_q[i].size() == 0);
    end
  end

  // monitor: logs pops and accepted words, tracks protocol violations
  always @(negedge clk) begin
    pop_s = {pop3, pop2, pop1, pop0};
    if ($countones(pop_s) > 1) viol_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (pop_s[i]) begin
        if (empty_v[i]) viol_cnt++;
        pop_log.push_back('{cyc, 2'(i), 10'd0});
      end
    end
    if (prev_valid && !prev_ready && !prev_reset &&
        (!out_valid || {out_lane, out_data} !== prev_word)) viol_cnt++;
    if (out_valid && out_ready) begin
      obs_q.push_back('{cyc, out_lane, out_data});
      xfer_total++;
    end
    if (idle && !prev_idle) idle_rise_cyc = cyc;
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_reset = reset;
    prev_idle  = idle;
    prev_word  = {out_lane, out_data};
  end

  initial begin
    #950000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required finish before 95000", cyc);
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    enable = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) lane_q[i].delete();
    tick();
    tick();
    reset = 1'b0;
    pop_log.delete();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_obs(input int n, input int budget);
    int k;
    k = 0;
    while (obs_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (obs_q.size() < n) begin
      errors++;
      $display("FAIL wait_obs: got %0d words, required %0d within %0d cycles", obs_q.size(), n, budget);
    end
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (out_data !== 10'h000) begin errors++; $display("FAIL reset_out_data: got %h required 000", out_data); end
    checks++; if (out_lane !== 2'd0) begin errors++; $display("FAIL reset_out_lane: got %0d required 0", out_lane); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b required 1", idle); end
    checks++; if (fwd_count !== 16'h0000) begin errors++; $display("FAIL reset_fwd_count: got %h required 0000", fwd_count); end
    checks++; if ({pop3, pop2, pop1, pop0} !== 4'h0) begin errors++; $display("FAIL reset_pops: got %b required 0000", {pop3, pop2, pop1, pop0}); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
  endtask

  task automatic test_single_lane();
    do_reset();
    lane_q[2].push_back(10'h2A1);
    lane_q[2].push_back(10'h2A2);
    lane_q[2].push_back(10'h2A3);
    exp_q.push_back({2'd2, 10'h2A1});
    exp_q.push_back({2'd2, 10'h2A2});
    exp_q.push_back({2'd2, 10'h2A3});
    out_ready = 1'b1;
    tick();
    enable = 1'b1;
    wait_obs(3, 40);
    tick();
    tick();
    @(negedge clk);
    checks++; if (pop_log.size() !== 3) begin errors++; $display("FAIL single_pop_count: got %0d required 3", pop_log.size()); end
    for (int i = 0; i < pop_log.size() && i < 3; i++) begin
      checks++;
      if (pop_log[i].lane !== 2'd2 || pop_log[i].cyc !== pop_log[0].cyc + i) begin
        errors++; $display("FAIL single_pop[%0d]: got lane %0d cycle %0d required lane 2 cycle %0d", i, pop_log[i].lane, pop_log[i].cyc, pop_log[0].cyc + i);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size()) begin
        errors++; $display("FAIL single_word[%0d]: got nothing required %h", i, exp_q[i]);
      end else if ({obs_q[i].lane, obs_q[i].data} !== exp_q[i]) begin
        errors++; $display("FAIL single_word[%0d]: got %h required %h", i, {obs_q[i].lane, obs_q[i].data}, exp_q[i]);
      end else if (i < pop_log.size() && obs_q[i].cyc !== pop_log[i].cyc + 2) begin
        errors++; $display("FAIL single_latency[%0d]: got cycle %0d required %0d", i, obs_q[i].cyc, pop_log[i].cyc + 2);
      end
    end
    checks++; if (fwd_count !== 16'd3) begin errors++; $display("FAIL single_fwd_count: got %0d required 3", fwd_count); end
    tick();
    enable = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle_after: got %b required 1", idle); end
  endtask

  task automatic test_all_lanes();
    do_reset();
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 2; k++) lane_q[l].push_back({2'(3 - l), 4'(l), 4'(k)});
    for (int k = 0; k < 2; k++)
      for (int l = 0; l < 4; l++) exp_q.push_back({2'(l), 2'(3 - l), 4'(l), 4'(k)});
    out_ready = 1'b1;
    tick();
    enable = 1'b1;
    wait_obs(8, 60);
    tick();
    @(negedge clk);
    checks++; if (pop_log.size() !== 8) begin errors++; $display("FAIL rr_pop_count: got %0d required 8", pop_log.size()); end
    for (int i = 0; i < pop_log.size() && i < 8; i++) begin
      checks++;
      if (pop_log[i].lane !== 2'(i % 4)) begin errors++; $display("FAIL rr_pop_lane[%0d]: got %0d required %0d", i, pop_log[i].lane, i % 4); end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size()) begin
        errors++; $display("FAIL rr_word[%0d]: got nothing required %h", i, exp_q[i]);
      end else if ({obs_q[i].lane, obs_q[i].data} !== exp_q[i]) begin
        errors++; $display("FAIL rr_word[%0d]: got %h required %h", i, {obs_q[i].lane, obs_q[i].data}, exp_q[i]);
      end else if (obs_q[i].cyc !== obs_q[0].cyc + i) begin
        errors++; $display("FAIL rr_throughput[%0d]: got cycle %0d required %0d", i, obs_q[i].cyc, obs_q[0].cyc + i);
      end
    end
    checks++; if (fwd_count !== 16'd8) begin errors++; $display("FAIL rr_fwd_count: got %0d required 8", fwd_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    lane_q[0].push_back(10'h301);
    lane_q[0].push_back(10'h302);
    lane_q[3].push_back(10'h0F1);
    lane_q[3].push_back(10'h0F2);
    exp_q.push_back({2'd0, 10'h301});
    exp_q.push_back({2'd3, 10'h0F1});
    exp_q.push_back({2'd0, 10'h302});
    exp_q.push_back({2'd3, 10'h0F2});
    tick();
    enable = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    checks++; if (pop_log.size() !== 2) begin errors++; $display("FAIL bp_pop_count: got %0d required 2", pop_log.size()); end
    if (pop_log.size() >= 2) begin
      checks++;
      if (pop_log[0].lane !== 2'd0 || pop_log[1].lane !== 2'd3) begin
        errors++; $display("FAIL bp_pop_order: got %0d,%0d required 0,3", pop_log[0].lane, pop_log[1].lane);
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 10'h301 || out_lane !== 2'd0) begin
      errors++; $display("FAIL bp_head: got valid %b data %h lane %0d required valid 1 data 301 lane 0", out_valid, out_data, out_lane);
    end
    tick();
    out_ready = 1'b1;
    wait_obs(4, 40);
    tick();
    @(negedge clk);
    checks++; if (obs_q.size() !== 4) begin errors++; $display("FAIL bp_word_count: got %0d required 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size()) begin
        errors++; $display("FAIL bp_word[%0d]: got nothing required %h", i, exp_q[i]);
      end else if ({obs_q[i].lane, obs_q[i].data} !== exp_q[i]) begin
        errors++; $display("FAIL bp_word[%0d]: got %h required %h", i, {obs_q[i].lane, obs_q[i].data}, exp_q[i]);
      end
    end
    checks++; if (fwd_count !== 16'd4) begin errors++; $display("FAIL bp_fwd_count: got %0d required 4", fwd_count); end
  endtask

  task automatic test_flush();
    int fall_cyc;
    int last_cyc;
    do_reset();
    lane_q[1].push_back(10'h1C0);
    lane_q[1].push_back(10'h1C1);
    lane_q[1].push_back(10'h1C2);
    lane_q[2].push_back(10'h2D0);
    lane_q[2].push_back(10'h2D1);
    exp_q.push_back({2'd1, 10'h1C0});
    exp_q.push_back({2'd2, 10'h2D0});
    out_ready = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    fall_cyc = cyc;
    repeat (15) tick();
    @(negedge clk);
    checks++; if (pop_log.size() !== 2) begin errors++; $display("FAIL flush_pop_count: got %0d required 2", pop_log.size()); end
    if (pop_log.size() > 0) begin
      checks++;
      if (pop_log[pop_log.size() - 1].cyc !== fall_cyc) begin
        errors++; $display("FAIL flush_last_pop: got cycle %0d required %0d", pop_log[pop_log.size() - 1].cyc, fall_cyc);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size()) begin
        errors++; $display("FAIL flush_word[%0d]: got nothing required %h", i, exp_q[i]);
      end else if ({obs_q[i].lane, obs_q[i].data} !== exp_q[i]) begin
        errors++; $display("FAIL flush_word[%0d]: got %h required %h", i, {obs_q[i].lane, obs_q[i].data}, exp_q[i]);
      end
    end
    checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL flush_word_count: got %0d required 2", obs_q.size()); end
    last_cyc = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1].cyc : -100;
    checks++; if (idle_rise_cyc !== last_cyc + 1) begin errors++; $display("FAIL flush_idle_rise: got cycle %0d required %0d", idle_rise_cyc, last_cyc + 1); end
    checks++; if (idle !== 1'b1 || dbg_state !== 2'd0) begin errors++; $display("FAIL flush_end: got idle %b state %0d required idle 1 state 0", idle, dbg_state); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    lane_q[0].push_back(10'h3E0);
    lane_q[0].push_back(10'h3E1);
    lane_q[0].push_back(10'h3E2);
    lane_q[0].push_back(10'h3E3);
    tick();
    enable = 1'b1;
    repeat (4) tick();
    out_ready = 1'b1;
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || pop0 !== 1'b1) begin errors++; $display("FAIL midrst_setup: got valid %b pop0 %b required 1 1", out_valid, pop0); end
    tick();
    reset = 1'b0;
    obs_q.delete();
    pop_log.delete();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b required 0", out_valid); end
    checks++; if (fwd_count !== 16'h0000) begin errors++; $display("FAIL midrst_fwd_count: got %h required 0000", fwd_count); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL midrst_idle: got %b required 1", idle); end
    checks++; if (out_data !== 10'h000 || out_lane !== 2'd0) begin errors++; $display("FAIL midrst_out_data: got %h lane %0d required 000 lane 0", out_data, out_lane); end
    repeat (6) tick();
    @(negedge clk);
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL midrst_discard: got %0d words after reset required 0", obs_q.size()); end
    checks++; if (pop_log.size() !== 0) begin errors++; $display("FAIL midrst_pops: got %0d pops after reset required 0", pop_log.size()); end
  endtask

  task automatic test_wrap();
    int base;
    int k;
    do_reset();
    for (int l = 0; l < 4; l++)
      for (int j = 0; j < 16386; j++) lane_q[l].push_back(10'(j));
    out_ready = 1'b1;
    base = xfer_total;
    tick();
    enable = 1'b1;
    k = 0;
    while (xfer_total - base < 65534 && k < 70000) begin
      tick();
      k++;
    end
    out_ready = 1'b0;
    obs_q.delete();
    pop_log.delete();
    checks++; if (xfer_total - base !== 65534) begin errors++; $display("FAIL wrap_preload: got %0d transfers required 65534", xfer_total - base); end
    @(negedge clk);
    checks++; if (fwd_count !== 16'hFFFE) begin errors++; $display("FAIL wrap_pre: got %h required fffe", fwd_count); end
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (fwd_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_1: got %h required ffff", fwd_count); end
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (fwd_count !== 16'h0000) begin errors++; $display("FAIL wrap_2: got %h required 0000", fwd_count); end
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (fwd_count !== 16'h0001) begin errors++; $display("FAIL wrap_3: got %h required 0001", fwd_count); end
  endtask

  task automatic test_protocol();
    @(negedge clk);
    checks++; if (viol_cnt !== 0) begin errors++; $display("FAIL protocol: got %0d violations required 0", viol_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_all_lanes();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_wrap();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_egress_drain.md
Name: tl_egress_drain

Overview:
- Downstream neighbour of the transaction-layer core.
- Drains the four output FIFOs (lanes 0-3) with round-robin pops and merges their 10-bit words into one ready/valid egress stream tagged with the source lane.
- Absorbs the one-cycle FIFO read latency with a 2-entry skid buffer, so no word is lost under backpressure.
- Exports an idle flag and a forwarded-word counter for the bench and for the top-level FSM.

Parameters:
- DATA_W, 10, word width; bits [9:8] carry the destination class, and the block passes them through untouched.
- CNT_W, 16, width of fwd_count.
- SKID_DEPTH, 2, skid-buffer entries; fixed at 2, and other values are unsupported.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  high while the top-level FSM is in its ACTIVE state; gates new pops.
- empty0..empty3  in  1 each  output-FIFO empty flags.
- fifo_data0..fifo_data3  in  DATA_W each  output-FIFO read data, valid the cycle after the pop.
- pop0..pop3  out  1 each  FIFO pop strobes; at most one is high per cycle.
- out_ready  in  1  egress sink ready.
- out_valid  out  1  egress word valid.
- out_data  out  DATA_W  egress word.
- out_lane  out  2  source lane of out_data.
- idle  out  1  high when in IDLE with nothing buffered or in flight.
- fwd_count  out  CNT_W  count of words accepted by the sink; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - pop0..3 = 0, out_valid = 0, out_data = 0, out_lane = 0.
  - idle = 1, fwd_count = 0.
  - RR pointer = 0, occupancy = 0, inflight = 0, state = IDLE.
- FIFO contract:
  - Pop in cycle t puts the word on fifo_dataN in cycle t+1.
  - emptyN is correct for the post-pop contents in cycle t+1.
- Pop eligibility in cycle t requires all of:
  - state == RUN;
  - at least one emptyN == 0;
  - (occupancy + inflight) < SKID_DEPTH, where inflight = 1 if a pop was issued in t-1.
- Arbitration:
  - Search lanes starting at the RR pointer, ascending with wrap 3->0, skipping empty lanes.
  - The first non-empty lane is granted and its popN is asserted.
  - The pointer becomes granted+1 mod 4.
  - If no lane pops, the pointer holds.
- Capture: in t+1 the returning word and its lane id are written at the skid tail; occupancy increments.
- Egress:
  - out_valid = (occupancy > 0); out_data/out_lane come from the skid head.
  - A transfer occurs when out_valid && out_ready: pop the head, occupancy decrements, fwd_count increments.
  - A capture and a transfer in the same cycle leave occupancy unchanged.
  - Order is preserved; a word never leaves before an older one.
- Throughput: with out_ready held high and data available, one word per cycle.
- Backpressure:
  - While out_ready = 0, out_valid/out_data/out_lane hold stable.
  - At most SKID_DEPTH words are outstanding; popping stops until there is room.
- States:
  - IDLE: no pops. Goes to RUN when enable = 1.
  - RUN: pops per the rules above. Goes to FLUSH when enable = 0.
  - FLUSH: no new pops; in-flight words are still captured and buffered words still egress. Goes to RUN if enable returns to 1. Goes to IDLE when occupancy == 0 and inflight == 0.
- idle = (state == IDLE) && occupancy == 0 && inflight == 0.
- All-empty in RUN: stays in RUN with no pops; out_valid drops once the skid buffer drains.
- Reset mid-operation: skid contents and any in-flight word are discarded, and all outputs return to their reset values the next cycle. Flushing data before asserting reset is the top level's responsibility.
- fwd_count wraps from 0xFFFF to 0 without any flag.

Decomposition:
- Shared package tl_pkg holds:
  - DATA_W and LANES = 4;
  - drain state encodings DRN_IDLE = 2'd0, DRN_RUN = 2'd1, DRN_FLUSH = 2'd2;
  - the lane-id field width of 2.
- Sub-module tl_skid_buf: a 2-entry FIFO storing {lane, data} with push/pop/occupancy outputs.
- Arbiter, FSM and counter stay in tl_egress_drain.

Test Plan:
- Reset then enable = 1, only lane 2 non-empty holding 0x2A1, 0x2A2, 0x2A3, out_ready = 1:
  - pop2 high on 3 consecutive cycles;
  - out_data 0x2A1/0x2A2/0x2A3 with out_lane = 2, each 2 cycles after its pop;
  - fwd_count = 3.
- All lanes non-empty, each holding 2 words, out_ready = 1:
  - pop order 0,1,2,3,0,1,2,3;
  - out_lane sequence matches;
  - fwd_count = 8.
- Lanes 0 and 3 loaded, out_ready = 0 for 10 cycles:
  - exactly 2 pops issued, then all pops stay 0;
  - out_valid = 1 with the head held stable;
  - on raising out_ready, the words drain in pop order with none lost or duplicated.
- Lanes loaded in RUN, enable dropped in the same cycle a pop issues:
  - the in-flight word is still captured and the buffered words egress;
  - idle rises exactly one cycle after the last transfer;
  - no pops are issued after enable falls.
- Reset asserted with occupancy = 2 and a pop in flight:
  - next cycle out_valid = 0, fwd_count = 0, idle = 1;
  - the discarded word never appears on out_data.
- Preload fwd_count near wrap via 0xFFFE transfers (or a forced count), then 3 transfers:
  - fwd_count reads 0xFFFF, 0x0000, 0x0001.
